morse_encoder: RTL and testbench
================================

# morse_encoder

Parametrised Morse code transmitter for the lab designs. It accepts one letter A–Z per request through a start/ready handshake. It then drives a single LED with timed marks and spaces built from a prescaled unit tick. It generalises the fixed A–H, half-second LEDR[0] blinker with several additions:
- a full alphabet;
- standard ITU dot/dash/gap ratios;
- a programmable unit length;
- busy/done/error status;
- an optional repeat mode.

## Interface
Parameters:
- DIV, 25000000: clock cycles per Morse unit (0.5 s at 50 MHz); must be ≥2.
- CW, $clog2(3*DIV): width of the unit/duration counter.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request; sampled only while ready=1.
- letter  in  5  0=A … 25=Z; latched when start is accepted.
- repeat  in  1  sampled at the end of each letter; 1 means retransmit the latched letter.
- ready  out  1  high in IDLE (equals !busy).
- busy  out  1  high while transmitting.
- led  out  1  Morse output (1 = mark); registered.
- done  out  1  one-cycle pulse at the end of a letter.
- err  out  1  one-cycle pulse when start is given with letter ≥26.
- sym_idx  out  2  index of the element currently being sent (0 = first).

## Operation
- Letter lookup:
  - a lookup function gives {len[2:0], pat[3:0]}, with len = 1–4 elements;
  - pat bit = 1 means dash; bits are sent MSB-first from bit len-1;
  - A = {2, 4'b0001}, E = {1, 4'b0000}, T = {1, 4'b0001}.
- Element durations:
  - dot mark = 1 unit; dash mark = 3 units;
  - inter-element space = 1 unit;
  - letter gap after the last mark = 3 units.
- States: IDLE, MARK, SPACE, LGAP.
- From IDLE:
  - if start=1 and letter<26: latch letter, load len/pat, set sym_idx=0, go to MARK;
  - if start=1 and letter≥26: pulse err, stay in IDLE.
- MARK: led=1 for the element duration. Then go to SPACE, or to LGAP if sym_idx = len-1.
- SPACE: led=0 for 1 unit, increment sym_idx, go to MARK.
- LGAP: led=0 for 3 units, then pulse done and:
  - repeat=1: go to MARK with sym_idx=0 (no IDLE cycle; ready stays 0);
  - repeat=0: go to IDLE.
- Busy handling: start while busy is ignored. letter changes while busy have no effect.
- Unit counting:
  - a single down-counter is loaded with DIV×units−1 on each state entry;
  - the state advances when the counter reaches 0;
  - there is no free-running prescaler, so the first element is full length.
- Reset values: led=0, ready=1, busy=0, done=0, err=0, sym_idx=0, state=IDLE. Reset asserted mid-letter forces led=0 immediately (asynchronously).

## Timing
- Start sampled at edge E0 → from E0: led=1, busy=1, ready=0.
- Latency from accept to first mark: 0 cycles after the accepting edge.
- A letter lasts (sum of mark units + (len−1) + 3)·DIV cycles.
- done is high for exactly the one cycle after the final LGAP count. In that same cycle:
  - ready=1 if repeat=0;
  - led=1 if repeat=1.
- A new start is accepted in the done cycle when repeat=0, which gives back-to-back letters.
- err is high in the cycle after the offending start edge. No state change.

## Structure
- Package morse_pkg:
  - the state enum;
  - the 26-entry lookup function returning {len, pat};
  - constants DOT_U=1, DASH_U=3, GAP_U=1, LGAP_U=3.
- A sub-module is natural: morse_timer (load value, load strobe, expired flag), holding the CW-bit down-counter.
- The FSM, the latched pattern and sym_idx stay in morse_encoder.

## Test plan
All scenarios use DIV=4.
- A: start at E0 with letter=0 → led high E0–E3, low E4–E7, high E8–E19, low E20–E31; done at E32; ready at E32.
- E then T back-to-back: E (letter=4) gives done at E16. A second start at E16 with letter=19 gives led high E16–E27 and done at E40.
- Invalid: letter=26 with start → err pulse one cycle; ready stays 1; led stays 0.
- Repeat: letter=4 with repeat=1 → done at E16 and E32; led high E16–E19 and E32–E35; busy never drops. Clearing repeat before E28 → IDLE at E32.
- Start while busy: during A, pulse start with letter=25 at E10 → ignored; the waveform is identical to the A scenario.
- Reset mid-letter: during a B dash (letter=1), assert reset at E6+half cycle → led=0 and ready=1 asynchronously. After release, start with letter=0 produces the exact A waveform.

Source files
------------

// File: rtl/morse_pkg.sv
// morse_pkg: shared definitions for the Morse code transmitter.
//   - FSM state codes (IDLE, MARK, SPACE, LGAP)
//   - element/gap lengths in Morse units
//   - morse_lookup(): letter index 0..25 -> {len[2:0], pat[3:0]}
//   - is_dash(): selects one element of a looked-up pattern
package morse_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MARK  = 2'd1;
    localparam logic [1:0] SPACE = 2'd2;
    localparam logic [1:0] LGAP  = 2'd3;

    localparam int DOT_U  = 1;
    localparam int DASH_U = 3;
    localparam int GAP_U  = 1;
    localparam int LGAP_U = 3;

    // pat bit = 1 is a dash; the first element sent is bit len-1.
    function automatic logic [6:0] morse_lookup(input logic [4:0] l);
        logic [6:0] r;
        case (l)
            5'd0:  r = {3'd2, 4'b0001}; // A .-
            5'd1:  r = {3'd4, 4'b1000}; // B -...
            5'd2:  r = {3'd4, 4'b1010}; // C -.-.
            5'd3:  r = {3'd3, 4'b0100}; // D -..
            5'd4:  r = {3'd1, 4'b0000}; // E .
            5'd5:  r = {3'd4, 4'b0010}; // F ..-.
            5'd6:  r = {3'd3, 4'b0110}; // G --.
            5'd7:  r = {3'd4, 4'b0000}; // H ....
            5'd8:  r = {3'd2, 4'b0000}; // I ..
            5'd9:  r = {3'd4, 4'b0111}; // J .---
            5'd10: r = {3'd3, 4'b0101}; // K -.-
            5'd11: r = {3'd4, 4'b0100}; // L .-..
            5'd12: r = {3'd2, 4'b0011}; // M --
            5'd13: r = {3'd2, 4'b0010}; // N -.
            5'd14: r = {3'd3, 4'b0111}; // O ---
            5'd15: r = {3'd4, 4'b0110}; // P .--.
            5'd16: r = {3'd4, 4'b1101}; // Q --.-
            5'd17: r = {3'd3, 4'b0010}; // R .-.
            5'd18: r = {3'd3, 4'b0000}; // S ...
            5'd19: r = {3'd1, 4'b0001}; // T -
            5'd20: r = {3'd3, 4'b0001}; // U ..-
            5'd21: r = {3'd4, 4'b0001}; // V ...-
            5'd22: r = {3'd3, 4'b0011}; // W .--
            5'd23: r = {3'd4, 4'b1001}; // X -..-
            5'd24: r = {3'd4, 4'b1011}; // Y -.--
            5'd25: r = {3'd4, 4'b1100}; // Z --..
            default: r = 7'd0;
        endcase
        return r;
    endfunction

    // Element idx (0 = first sent) of a pattern of length len.
    function automatic logic is_dash(input logic [3:0] pat, input logic [2:0] len,
                                     input logic [1:0] idx);
        logic [2:0] pos;
        pos = len - 3'd1 - {1'b0, idx};
        return pat[pos[1:0]];
    endfunction

endpackage

// File: rtl/morse_timer.sv
// morse_timer: down-counter that times each Morse element or gap.
//   clk, rst     : clock, asynchronous active-high reset
//   load         : reload the counter with load_val this cycle
//   load_val     : cycles-minus-one for the interval being started
//   expired      : counter is at zero (interval ends on the next edge)
module morse_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expired
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/morse_encoder.sv
// morse_encoder: Morse transmitter for one letter A..Z per start/ready handshake.
//   CLOCK_50  : clock          reset   : asynchronous active-high reset
//   start     : request        letter  : 0=A .. 25=Z, latched on accept
//   repeat_en : at end of letter, 1 = send the latched letter again
//   ready     : idle           busy    : transmitting (= !ready)
//   led       : Morse output (1 = mark), registered
//   done      : one-cycle pulse after each letter's final gap
//   err       : one-cycle pulse after a start with letter >= 26
//   sym_idx   : index of the element currently being sent
module morse_encoder
    import morse_pkg::*;
#(
    parameter int DIV = 25000000,
    parameter int CW  = $clog2(3*DIV)
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] letter,
    input  logic       repeat_en,
    output logic       ready,
    output logic       busy,
    output logic       led,
    output logic       done,
    output logic       err,
    output logic [1:0] sym_idx
);

    localparam logic [CW-1:0] DOT_LD  = CW'(DIV*DOT_U  - 1);
    localparam logic [CW-1:0] DASH_LD = CW'(DIV*DASH_U - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(DIV*GAP_U  - 1);
    localparam logic [CW-1:0] LGAP_LD = CW'(DIV*LGAP_U - 1);

    logic [1:0]    state, state_n;
    logic [1:0]    sym_n;
    logic [2:0]    len;
    logic [3:0]    pat;
    logic [6:0]    lk;
    logic          req_ok, accept, load, expired, done_n, err_n;
    logic [CW-1:0] load_val;

    assign lk     = morse_lookup(letter);
    assign req_ok = start && (letter < 5'd26);

    always_comb begin
        state_n  = state;
        sym_n    = sym_idx;
        accept   = 1'b0;
        load     = 1'b0;
        load_val = DOT_LD;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (req_ok) begin
                    accept   = 1'b1;
                    state_n  = MARK;
                    sym_n    = 2'd0;
                    load     = 1'b1;
                    load_val = is_dash(lk[3:0], lk[6:4], 2'd0) ? DASH_LD : DOT_LD;
                end else if (start) begin
                    err_n = 1'b1;
                end
            end
            MARK: begin
                if (expired) begin
                    load = 1'b1;
                    if ({1'b0, sym_idx} == len - 3'd1) begin
                        state_n  = LGAP;
                        load_val = LGAP_LD;
                    end else begin
                        state_n  = SPACE;
                        load_val = GAP_LD;
                    end
                end
            end
            SPACE: begin
                if (expired) begin
                    state_n  = MARK;
                    sym_n    = sym_idx + 2'd1;
                    load     = 1'b1;
                    load_val = is_dash(pat, len, sym_idx + 2'd1) ? DASH_LD : DOT_LD;
                end
            end
            default: begin // LGAP
                if (expired) begin
                    done_n = 1'b1;
                    if (repeat_en) begin
                        state_n  = MARK;
                        sym_n    = 2'd0;
                        load     = 1'b1;
                        load_val = is_dash(pat, len, 2'd0) ? DASH_LD : DOT_LD;
                    end else if (req_ok) begin
                        // A start on the closing edge chains the next letter
                        // with no idle cycle in between.
                        accept   = 1'b1;
                        state_n  = MARK;
                        sym_n    = 2'd0;
                        load     = 1'b1;
                        load_val = is_dash(lk[3:0], lk[6:4], 2'd0) ? DASH_LD : DOT_LD;
                    end else begin
                        state_n = IDLE;
                        err_n   = start;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sym_idx <= 2'd0;
            led     <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            sym_idx <= sym_n;
            led     <= (state_n == MARK);
            done    <= done_n;
            err     <= err_n;
        end
    end

    // Pattern is only meaningful while busy, so it needs no reset.
    always_ff @(posedge CLOCK_50) begin
        if (accept) begin
            len <= lk[6:4];
            pat <= lk[3:0];
        end
    end

    assign ready = (state == IDLE);
    assign busy  = !ready;

    morse_timer #(.CW(CW)) u_timer (
        .clk      (CLOCK_50),
        .rst      (reset),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

endmodule

// File: tb/tb_morse_encoder.sv
// Bench for morse_encoder with DIV=4: expected per-cycle outputs are built
// from dot/dash strings and ITU timing rules, then compared every cycle.
module tb_morse_encoder;

    localparam int DIV = 4;
    localparam int CW  = $clog2(3*DIV);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] letter = 5'd0;
    logic       repeat_en = 1'b0;
    logic       ready, busy, led, done, err;
    logic [1:0] sym_idx;

    always #5 clk = ~clk;

    morse_encoder #(.DIV(DIV), .CW(CW)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .start     (start),
        .letter    (letter),
        .repeat_en (repeat_en),
        .ready     (ready),
        .busy      (busy),
        .led       (led),
        .done      (done),
        .err       (err),
        .sym_idx   (sym_idx)
    );

    typedef struct packed {
        logic       led;
        logic       busy;
        logic       done;
        logic       err;
        logic [1:0] sym;
    } exp_t;

    string codes [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                          "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                          "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                          "-.--", "--.."};

    exp_t q[$];
    exp_t s[$];
    int   cur = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle expectation for one letter, starting the cycle after
    // the accepting edge and ending with the done cycle.
    task automatic make_seq(input int l);
        string c;
        int    units;
        int    n;
        exp_t  e;
        s.delete();
        c = codes[l];
        n = c.len();
        for (int i = 0; i < n; i++) begin
            units = (c[i] == "-") ? 3 : 1;
            for (int k = 0; k < DIV*units; k++) begin
                e = '{led: 1'b1, busy: 1'b1, done: 1'b0, err: 1'b0, sym: 2'(i)};
                s.push_back(e);
            end
            if (i != n-1)
                for (int k = 0; k < DIV; k++) begin
                    e = '{led: 1'b0, busy: 1'b1, done: 1'b0, err: 1'b0, sym: 2'(i)};
                    s.push_back(e);
                end
        end
        for (int k = 0; k < 3*DIV; k++) begin
            e = '{led: 1'b0, busy: 1'b1, done: 1'b0, err: 1'b0, sym: 2'(n-1)};
            s.push_back(e);
        end
        e = '{led: 1'b0, busy: 1'b0, done: 1'b1, err: 1'b0, sym: 2'd0};
        s.push_back(e);
    endtask

    // Start a letter; if the pending entry is a done cycle, the new letter
    // begins in that same cycle.
    task automatic launch(input int l);
        exp_t e;
        make_seq(l);
        if (q.size() == 1) begin
            e = s[0];
            e.done = 1'b1;
            s[0] = e;
            q.delete();
        end
        foreach (s[i]) q.push_back(s[i]);
    endtask

    // Drive inputs for the next rising edge and update the model.
    task automatic step(input logic st, input logic [4:0] lt, input logic rp);
        exp_t e;
        @(negedge clk);
        #1;
        start = st;
        letter = lt;
        repeat_en = rp;
        if (q.size() == 1 && q[0].done) begin
            if (rp) begin
                launch(cur);
            end else if (st) begin
                if (lt < 5'd26) begin
                    cur = int'(lt);
                    launch(cur);
                end else begin
                    e = q[0];
                    e.err = 1'b1;
                    q[0] = e;
                end
            end
        end else if (q.size() == 0 && st) begin
            if (lt < 5'd26) begin
                cur = int'(lt);
                launch(cur);
            end else begin
                e = '{led: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b1, sym: 2'd0};
                q.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 1000) begin
            step(1'b0, 5'd0, 1'b0);
            guard++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        // Pin the model against hand-derived letter timings.
        make_seq(0);
        chk("model_A_len", 32'(s.size()), 32'd33);
        chk("model_A_led3", 32'(s[3].led), 32'd1);
        chk("model_A_led4", 32'(s[4].led), 32'd0);
        chk("model_A_led7", 32'(s[7].led), 32'd0);
        chk("model_A_led8", 32'(s[8].led), 32'd1);
        chk("model_A_led19", 32'(s[19].led), 32'd1);
        chk("model_A_led20", 32'(s[20].led), 32'd0);
        chk("model_A_busy31", 32'(s[31].busy), 32'd1);
        chk("model_A_done32", 32'(s[32].done), 32'd1);
        make_seq(4);
        chk("model_E_len", 32'(s.size()), 32'd17);
        make_seq(19);
        chk("model_T_len", 32'(s.size()), 32'd25);
        chk("model_T_led11", 32'(s[11].led), 32'd1);
        chk("model_T_led12", 32'(s[12].led), 32'd0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_sym", 32'(sym_idx), 32'd0);
        #1 reset = 1'b0;

        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    e = (q.size() > 0) ? q.pop_front() : exp_t'(0);
                    chk("led", 32'(led), 32'(e.led));
                    chk("busy", 32'(busy), 32'(e.busy));
                    chk("ready", 32'(ready), 32'(!e.busy));
                    chk("done", 32'(done), 32'(e.done));
                    chk("err", 32'(err), 32'(e.err));
                    if (e.busy) chk("sym_idx", 32'(sym_idx), 32'(e.sym));
                end
            end
            begin : stim
                // A
                step(1'b1, 5'd0, 1'b0);
                drain();
                // E then T back-to-back
                step(1'b1, 5'd4, 1'b0);
                repeat (15) step(1'b0, 5'd0, 1'b0);
                step(1'b1, 5'd19, 1'b0);
                chk("b2b_accept", 32'(q.size()), 32'd25);
                drain();
                // Invalid letter
                step(1'b1, 5'd26, 1'b0);
                repeat (3) step(1'b0, 5'd0, 1'b0);
                // Repeat, cleared before the second letter ends
                step(1'b1, 5'd4, 1'b1);
                repeat (27) step(1'b0, 5'd0, 1'b1);
                drain();
                // Start while busy is ignored
                step(1'b1, 5'd0, 1'b0);
                repeat (9) step(1'b0, 5'd0, 1'b0);
                step(1'b1, 5'd25, 1'b0);
                drain();
                // Reset during the dash of B
                step(1'b1, 5'd1, 1'b0);
                repeat (6) step(1'b0, 5'd0, 1'b0);
                @(negedge clk);
                #1;
                chk("pre_rst_led", 32'(led), 32'd1);
                reset = 1'b1;
                q.delete();
                #1;
                chk("async_rst_led", 32'(led), 32'd0);
                chk("async_rst_ready", 32'(ready), 32'd1);
                @(negedge clk);
                #1 reset = 1'b0;
                step(1'b1, 5'd0, 1'b0);
                drain();
                // Randomized traffic
                for (int i = 0; i < 600; i++) begin
                    logic       st, rp;
                    logic [4:0] lt;
                    st = ($urandom_range(0, 5) == 0);
                    lt = ($urandom_range(0, 9) == 0) ? 5'(26 + $urandom_range(0, 5))
                                                      : 5'($urandom_range(0, 25));
                    rp = ($urandom_range(0, 5) == 0);
                    step(st, lt, rp);
                end
                drain();
                step(1'b0, 5'd0, 1'b0);
            end
        join_any
        disable fork;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
